// File: rtl/seg7_readback.sv
// Converts two active-low seven-segment digits back into a byte, reporting each new stable
// pattern once over Valid/Ack. Define SEG7_READBACK_BLANK_EN to treat an all-off digit as 0.
module seg7_readback #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [6:0] HexHi,
  input  logic [6:0] HexLo,
  input  logic       Ack,
  output logic [7:0] Value,
  output logic       Valid,
  output logic       Error
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StArmed, StWait, StReport} state_e;

  state_e      state_q;
  logic [13:0] samp_q;
  logic [13:0] cap_q;
  logic [7:0]  run_q;
  logic        stable;
  logic        hi_ok, lo_ok;
  logic [3:0]  hi_nib, lo_nib;

  // Returns {legal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h10:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
`ifdef SEG7_READBACK_BLANK_EN
      7'h7F:   res = {1'b1, 4'h0};
`endif
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  always_comb begin
    {hi_ok, hi_nib} = seg_decode(samp_q[13:7]);
    {lo_ok, lo_nib} = seg_decode(samp_q[6:0]);
    stable          = (run_q == StableCnt);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      samp_q  <= 14'h3FFF;
      cap_q   <= 14'h3FFF;
      run_q   <= 8'd0;
      state_q <= StArmed;
      Value   <= 8'h00;
      Valid   <= 1'b0;
      Error   <= 1'b0;
    end else begin
      samp_q <= {HexHi, HexLo};
      if ({HexHi, HexLo} != samp_q) begin
        run_q <= 8'd0;
      end else if (!stable) begin
        run_q <= run_q + 8'd1;
      end

      case (state_q)
        StArmed, StWait: begin
          // A stable pattern identical to the last report is not re-reported.
          if (stable && (state_q == StArmed || samp_q != cap_q)) begin
            cap_q   <= samp_q;
            state_q <= StReport;
            Valid   <= 1'b1;
            if (hi_ok && lo_ok) begin
              Value <= {hi_nib, lo_nib};
              Error <= 1'b0;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        StReport: begin
          if (Ack) begin
            state_q <= StWait;
            Valid   <= 1'b0;
          end
        end
        default: begin
          state_q <= StArmed;
          Valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_readback.sv
// Randomized and directed bench for seg7_readback: two instances (STABLE_CYCLES 4 and 1)
// checked every cycle against a sliding-window reference model.
module tb_seg7_readback;

  localparam int S0 = 4;
  localparam int S1 = 1;

`ifdef SEG7_READBACK_BLANK_EN
  localparam bit BlankLegal = 1'b1;
`else
  localparam bit BlankLegal = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [6:0] hi0, lo0, hi1, lo1;
  logic       ack0, ack1;
  logic [7:0] value0, value1;
  logic       valid0, valid1, error0, error1;

  int n_checks;
  int n_errors;

  seg7_readback #(.STABLE_CYCLES(S0)) u_dut0 (
    .Clock(clk), .Reset(rst), .HexHi(hi0), .HexLo(lo0), .Ack(ack0),
    .Value(value0), .Valid(valid0), .Error(error0)
  );

  seg7_readback #(.STABLE_CYCLES(S1)) u_dut1 (
    .Clock(clk), .Reset(rst), .HexHi(hi1), .HexLo(lo1), .Ack(ack1),
    .Value(value1), .Valid(valid1), .Error(error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: recent sample history (index 0 newest) plus the report view.
  logic [13:0] m_hist [2][16];
  int          m_len   [2];
  bit          m_rep   [2];
  bit          m_armed [2];
  bit          m_err   [2];
  logic [7:0]  m_val   [2];
  logic [13:0] m_cap   [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit seg_legal(input logic [6:0] p);
    if (p == 7'h7F) return BlankLegal;
    foreach (seg_tbl[k]) if (seg_tbl[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] seg_value(input logic [6:0] p);
    foreach (seg_tbl[k]) if (seg_tbl[k] == p) return 4'(k);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) m_hist[i][j] = 14'h3FFF;
      m_len[i]   = 1;
      m_rep[i]   = 1'b0;
      m_armed[i] = 1'b1;
      m_err[i]   = 1'b0;
      m_val[i]   = 8'h00;
      m_cap[i]   = 14'h3FFF;
    end
  endtask

  // Stable means the last s+1 samples are identical; the reset blank counts as a sample.
  task automatic model_step(input int i, input int s, input logic [13:0] pat, input logic ack);
    bit          stable;
    logic [13:0] h;
    h      = m_hist[i][0];
    stable = (m_len[i] >= s + 1);
    for (int j = 1; j <= s; j++) if (m_hist[i][j] != h) stable = 1'b0;
    if (m_rep[i]) begin
      if (ack) m_rep[i] = 1'b0;
    end else if (stable && (m_armed[i] || h != m_cap[i])) begin
      m_armed[i] = 1'b0;
      m_rep[i]   = 1'b1;
      m_cap[i]   = h;
      if (seg_legal(h[13:7]) && seg_legal(h[6:0])) begin
        m_val[i] = {seg_value(h[13:7]), seg_value(h[6:0])};
        m_err[i] = 1'b0;
      end else begin
        m_err[i] = 1'b1;
      end
    end
    for (int j = 15; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
    m_hist[i][0] = pat;
    if (m_len[i] < 16) m_len[i]++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, S0, {hi0, lo0}, ack0);
      model_step(1, S1, {hi1, lo1}, ack1);
    end
    #1;
    check_eq("valid0", 32'(valid0), 32'(m_rep[0]));
    check_eq("value0", 32'(value0), 32'(m_val[0]));
    check_eq("error0", 32'(error0), 32'(m_err[0]));
    check_eq("valid1", 32'(valid1), 32'(m_rep[1]));
    check_eq("value1", 32'(value1), 32'(m_val[1]));
    check_eq("error1", 32'(error1), 32'(m_err[1]));
  endtask

  function automatic logic [6:0] rand_seg();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return seg_tbl[r];
    if (r < 18) return 7'h7F;
    return 7'($urandom);
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst  = 1'b1;
    ack0 = 1'b0;
    ack1 = 1'b0;
    hi0  = 7'h79;
    lo0  = 7'h24;
    hi1  = 7'h7F;
    lo1  = 7'h7F;
    #12;
    check_eq("rst_valid0", 32'(valid0), 32'd0);
    check_eq("rst_value0", 32'(value0), 32'd0);
    check_eq("rst_error0", 32'(error0), 32'd0);
    rst = 1'b0;

    // Basic latency: report after edge STABLE_CYCLES+2.
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) begin
        check_eq("t6_valid", 32'(valid1), 32'd1);
        check_eq("t6_error", 32'(error1), BlankLegal ? 32'd0 : 32'd1);
      end
      if (e == 5) check_eq("t1_early", 32'(valid0), 32'd0);
      if (e == 6) begin
        check_eq("t1_valid", 32'(valid0), 32'd1);
        check_eq("t1_value", 32'(value0), 32'h12);
        check_eq("t1_error", 32'(error0), 32'd0);
      end
    end
    ack0 = 1'b1;
    hi1  = 7'h40;
    lo1  = 7'h40;
    ack1 = 1'b1;
    tick();
    ack0 = 1'b0;
    ack1 = 1'b0;
    check_eq("t1_ackdrop", 32'(valid0), 32'd0);
    repeat (4) tick();
    check_eq("t6_valid2", 32'(valid1), 32'd1);
    check_eq("t6_value2", 32'(value1), 32'h00);
    check_eq("t6_error2", 32'(error1), 32'd0);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;

    // Illegal low digit keeps the old value.
    lo0 = 7'h7E;
    repeat (7) tick();
    check_eq("t3_valid", 32'(valid0), 32'd1);
    check_eq("t3_error", 32'(error0), 32'd1);
    check_eq("t3_value", 32'(value0), 32'h12);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;

    // Change while a report is pending.
    lo0 = 7'h24;
    repeat (7) tick();
    check_eq("t4_valid", 32'(valid0), 32'd1);
    hi0 = 7'h30;
    lo0 = 7'h19;
    repeat (10) tick();
    check_eq("t4_frozen", 32'(value0), 32'h12);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check_eq("t4_gap", 32'(valid0), 32'd0);
    tick();
    check_eq("t4_revalid", 32'(valid0), 32'd1);
    check_eq("t4_value", 32'(value0), 32'h34);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    repeat (10) tick();
    check_eq("t4_norepeat", 32'(valid0), 32'd0);

    // Glitch rejection: each pattern holds only 3 edges.
    for (int c = 0; c < 40; c++) begin
      lo0 = (((c / 3) % 2) == 1) ? 7'h19 : 7'h30;
      tick();
      check_eq("t2_glitch", 32'(valid0), 32'd0);
    end

    // Asynchronous reset between edges.
    hi0 = 7'h79;
    lo0 = 7'h24;
    repeat (8) tick();
    check_eq("t5_pre", 32'(valid0), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t5_valid", 32'(valid0), 32'd0);
    check_eq("t5_value", 32'(value0), 32'd0);
    check_eq("t5_error", 32'(error0), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        hi0 = rand_seg();
        lo0 = rand_seg();
      end
      if ($urandom_range(0, 3) == 0) begin
        hi1 = rand_seg();
        lo1 = rand_seg();
      end
      ack0 = ($urandom_range(0, 3) == 0);
      ack1 = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Reads the two active-low seven-segment buses driven by the ALU/register display path (high and low digit of the 8-bit register value) and converts them back into an 8-bit binary value. A pattern is reported only after it has held steady for a programmable number of cycles. Each new stable value is delivered once over a Valid/Ack handshake, and illegal segment patterns are flagged. The block sits beside the display encoders as an in-system checker and as the receive end of the segment interface.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive matching cycles before a pattern is accepted; legal range 1..255.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- HexHi  in  7  high-digit segments, active-low, bit0=a … bit6=g.
- HexLo  in  7  low-digit segments, same encoding.
- Ack  in  1  consumer accepts the current report.
- Value  out  8  {decoded HexHi nibble, decoded HexLo nibble}.
- Valid  out  1  report pending; held until Ack.
- Error  out  1  qualified by Valid; 1 = at least one digit pattern illegal.

## Operation
- Legal patterns (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Any other pattern is illegal and decodes to nibble 0.
- Sample register samp (14 bits) loads {HexHi,HexLo} every edge.
- Run counter run (8 bits):
  - Cleared to 0 when the inputs differ from samp.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - The pattern is stable when run == STABLE_CYCLES.
- Capture register cap holds the last reported 14-bit pattern.
- FSM states:
  - ARMED (after reset): on stable, capture and go to REPORT.
  - WAIT: on stable with samp != cap, capture and go to REPORT. A stable pattern equal to cap is ignored.
  - REPORT: Valid=1, with Value and Error frozen. Ack=1 moves to WAIT at that edge.
- Capture action:
  - cap <= samp.
  - If both digits are legal: Value <= decoded, Error <= 0.
  - If either digit is illegal: Error <= 1 and Value keeps its previous contents.
- Input changes during REPORT update samp and run only. The report is not altered.
- Ack outside REPORT is ignored.

## Timing
- Reset values: Value=8'h00, Valid=0, Error=0, samp=14'h3FFF (both blank), run=0, cap=14'h3FFF, state ARMED.
- Reset is asynchronous: Valid, Value and Error clear immediately, mid-report included.
- Latency: count the edge that first samples a new pattern as edge 1. Valid rises after edge STABLE_CYCLES+2 (edge 6 for the default).
- Ack may be high in the same cycle Valid is first high. Valid falls after that edge.
- Back-to-back reports: if a different pattern is already stable when Ack is taken, Valid re-asserts one edge later (one cycle low minimum).
- Glitch rejection: a pattern held for fewer than STABLE_CYCLES+1 sampled edges is never reported.

## Configuration
- SEG7_READBACK_BLANK_EN defined: 7'h7F (all segments off) is a legal pattern decoding to nibble 0, matching leading-zero-blanked displays.
- SEG7_READBACK_BLANK_EN undefined: 7'h7F is illegal and sets Error on capture. Without the macro, an all-blank display after reset therefore reports Valid with Error=1.

## Test plan
1. Macro defined, default STABLE_CYCLES:
   - Stimulus: release Reset, hold HexHi=79, HexLo=24.
   - Response: Valid rises after edge 6 with Value=8'h12 and Error=0. A one-cycle Ack drops Valid after that edge.
2. Glitch rejection:
   - Stimulus: toggle HexLo between 30 and 19 every 3 cycles for 40 cycles.
   - Response: Valid stays 0 throughout.
3. Illegal pattern:
   - Stimulus: after test 1, apply HexLo=7E.
   - Response: Valid with Error=1 and Value still 8'h12.
4. Change during an unacknowledged report:
   - Stimulus: while REPORT holds 8'h12, change the inputs to 30/19 and hold; Ack 10 cycles later.
   - Response: Value stays 8'h12 until Ack, then Valid is low one cycle and re-asserts with Value=8'h34.
   - Stimulus: hold the same pattern after that Ack.
   - Response: no further Valid.
5. Asynchronous reset mid-report:
   - Stimulus: assert Reset between clock edges while Valid=1.
   - Response: Valid=0, Value=0 and Error=0 before the next edge.
6. Macro undefined, STABLE_CYCLES=1:
   - Stimulus: release Reset with both inputs at 7F.
   - Response: Valid after edge 3 with Error=1.
   - Stimulus: then apply 40/40.
   - Response: Value=8'h00 with Error=0.
